// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - 3x3 window sequencer feeding the Sobel stage
//
// Buffers two image lines and builds a 3x3 neighbourhood around every
// interior pixel of a raster-order frame. A window is registered one cycle
// after the pixel that completes it is accepted.
//
// Optional feature macro: SOBEL_WIN_COORD_EN adds win_x / win_y outputs.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   start          begin a frame (sampled only while idle)
//   pix_in         input pixel, raster order
//   pix_in_valid   pix_in valid this cycle
//   pix_in_ready   pixel accepted when valid & ready
//   p00..p22       3x3 window, pRC = pixel(center_row-1+R, center_col-1+C)
//   win_valid      window outputs valid this cycle
//   busy           frame in progress
//   frame_done     one-cycle pulse with the final window of the frame
//   win_x, win_y   window center column/row (SOBEL_WIN_COORD_EN only)
module sobel_window_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_in_valid,
  output logic              pix_in_ready,
  output logic [DATA_W-1:0] p00,
  output logic [DATA_W-1:0] p01,
  output logic [DATA_W-1:0] p02,
  output logic [DATA_W-1:0] p10,
  output logic [DATA_W-1:0] p11,
  output logic [DATA_W-1:0] p12,
  output logic [DATA_W-1:0] p20,
  output logic [DATA_W-1:0] p21,
  output logic [DATA_W-1:0] p22,
  output logic              win_valid,
  output logic              busy,
  output logic              frame_done
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_fire;

  // lb_top holds row r-2, lb_mid holds row r-1 relative to the incoming row.
  logic [DATA_W-1:0] lb_top [IMG_W];
  logic [DATA_W-1:0] lb_mid [IMG_W];
  logic [DATA_W-1:0] top_rd;
  logic [DATA_W-1:0] mid_rd;

  // Column shift registers: [0] is column c-1, [1] is column c-2.
  logic [DATA_W-1:0] sh_top [2];
  logic [DATA_W-1:0] sh_mid [2];
  logic [DATA_W-1:0] sh_bot [2];

  assign accept   = pix_in_valid && ((state == PRIME) || (state == RUN));
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // Columns 0 and 1 never complete a window, so the shift registers need no
  // explicit flush at a row wrap.
  assign win_fire = accept && (state == RUN) && (col >= CW'(2));
  assign top_rd   = lb_top[col];
  assign mid_rd   = lb_mid[col];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pix_in_ready = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        pix_in_ready = 1'b1;
        if (accept && col_last && (row == RW'(1))) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        pix_in_ready = 1'b1;
        if (accept && col_last && row_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if ((state == IDLE) && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Read-before-write: the old middle line moves up, the new pixel lands in
  // the middle line, both at the column being accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= mid_rd;
      lb_mid[col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_top     <= '{default: '0};
      sh_mid     <= '{default: '0};
      sh_bot     <= '{default: '0};
      p00        <= '0;
      p01        <= '0;
      p02        <= '0;
      p10        <= '0;
      p11        <= '0;
      p12        <= '0;
      p20        <= '0;
      p21        <= '0;
      p22        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef SOBEL_WIN_COORD_EN
      win_x      <= '0;
      win_y      <= '0;
`endif
    end else begin
      win_valid  <= win_fire;
      frame_done <= win_fire && col_last && row_last;
      if (accept) begin
        sh_top[1] <= sh_top[0];
        sh_top[0] <= top_rd;
        sh_mid[1] <= sh_mid[0];
        sh_mid[0] <= mid_rd;
        sh_bot[1] <= sh_bot[0];
        sh_bot[0] <= pix_in;
      end
      if (win_fire) begin
        p00 <= sh_top[1];
        p01 <= sh_top[0];
        p02 <= top_rd;
        p10 <= sh_mid[1];
        p11 <= sh_mid[0];
        p12 <= mid_rd;
        p20 <= sh_bot[1];
        p21 <= sh_bot[0];
        p22 <= pix_in;
`ifdef SOBEL_WIN_COORD_EN
        win_x <= col - CW'(1);
        win_y <= row - RW'(1);
`endif
      end
    end
  end

endmodule
